// File: rtl/card_pkg.sv
// card_pkg: shared types and constants for the card shoe.
//  card_t        packed card {suit[5:4], rank[3:0]}, rank 1..13 (1 = ace)
//  shoe_state_t  shoe FSM states (fill, shuffle, ready, empty)
//  DECK_SIZE     cards per deck (fixed at 52)
package card_pkg;

   localparam int unsigned DECK_SIZE = 52;
   localparam int unsigned RANK_W    = 4;
   localparam int unsigned SUIT_W    = 2;
   localparam int unsigned CARD_W    = RANK_W + SUIT_W;
   // Wide enough for deck indices 0..51 and the remaining count 0..52.
   localparam int unsigned IDX_W     = 6;
   localparam int unsigned LFSR_W    = 16;

   localparam logic [RANK_W-1:0] RANK_ACE  = 4'd1;
   localparam logic [RANK_W-1:0] RANK_KING = 4'd13;

   typedef struct packed {
      logic [SUIT_W-1:0] suit;
      logic [RANK_W-1:0] rank;
   } card_t;

   typedef enum logic [1:0] {
      StFill,
      StShuffle,
      StReady,
      StEmpty
   } shoe_state_t;

endpackage

// File: rtl/card_shoe_lfsr.sv
// card_shoe_lfsr: 16-bit right-shifting Galois LFSR, seeded on reset only.
//  i_clk     system clock
//  i_reset   asynchronous active-low reset, loads SEED
//  i_enable  advance one step per cycle when high
//  o_rnd     low OUT_W bits of the LFSR state
module card_shoe_lfsr #(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter logic [15:0] TAPS  = 16'hB400,
   parameter int unsigned OUT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   output logic [OUT_W-1:0] o_rnd
);

   logic [15:0] stateQ;
   logic [15:0] stateD;

   always_comb begin
      stateD = stateQ;
      if (i_enable) begin
         stateD = {1'b0, stateQ[15:1]} ^ (stateQ[0] ? TAPS : 16'h0000);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         stateQ <= SEED;
      end else begin
         stateQ <= stateD;
      end
   end

   assign o_rnd = stateQ[OUT_W-1:0];

endmodule

// File: rtl/card_shoe.sv
// card_shoe: one 52-card deck, filled in order, Fisher-Yates shuffled from an
// LFSR, then dealt one card per request with a registered valid strobe.
//  i_clk              system clock
//  i_reset            asynchronous active-low reset
//  i_draw_req         one-cycle request for the next card (honoured in READY only)
//  i_shuffle_req      one-cycle request to refill and reshuffle (any state)
//  o_card             card dealt, meaningful while o_card_valid
//  o_card_valid       one-cycle strobe, one cycle after an accepted draw
//  o_ready            deck shuffled, draws accepted
//  o_empty            all cards dealt
//  o_cards_remaining  cards left in READY/EMPTY, else 0
// Build option: CARD_SHOE_AUTO_RESHUFFLE_EN makes EMPTY last a single cycle and
// regenerate the deck automatically.
module card_shoe
   import card_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int unsigned DECK_SIZE = card_pkg::DECK_SIZE
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_draw_req,
   input  logic             i_shuffle_req,
   output card_t            o_card,
   output logic             o_card_valid,
   output logic             o_ready,
   output logic             o_empty,
   output logic [IDX_W-1:0] o_cards_remaining
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECK_SIZE - 1);

   shoe_state_t        stateQ, stateD;
   logic [IDX_W-1:0]   idxQ, idxD;
   logic [IDX_W-1:0]   ptrQ, ptrD;
   logic [RANK_W-1:0]  rankQ, rankD;
   logic [SUIT_W-1:0]  suitQ, suitD;
   card_t              cardQ, cardD;
   logic               validQ, validD;
   logic               fillWe, swapWe;
   logic [IDX_W-1:0]   rnd;

   card_t deck [DECK_SIZE];

   card_shoe_lfsr #(
      .SEED  (LFSR_SEED),
      .TAPS  (16'hB400),
      .OUT_W (IDX_W)
   ) uLfsr (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_enable (1'b1),
      .o_rnd    (rnd)
   );

   always_comb begin
      stateD = stateQ;
      idxD   = idxQ;
      ptrD   = ptrQ;
      rankD  = rankQ;
      suitD  = suitQ;
      cardD  = cardQ;
      validD = 1'b0;
      fillWe = 1'b0;
      swapWe = 1'b0;

      if (i_shuffle_req) begin
         // Overrides everything, including a same-cycle draw.
         stateD = StFill;
         idxD   = '0;
         ptrD   = '0;
         rankD  = RANK_ACE;
         suitD  = '0;
      end else begin
         case (stateQ)
            StFill: begin
               fillWe = 1'b1;
               if (idxQ == LAST_IDX) begin
                  idxD   = LAST_IDX;
                  stateD = StShuffle;
               end else begin
                  idxD = idxQ + 6'd1;
               end
               // Suit counter wraps to 0 after the last king, leaving the
               // counters at ace of suit 0 for the next fill.
               if (rankQ == RANK_KING) begin
                  rankD = RANK_ACE;
                  suitD = suitQ + 2'd1;
               end else begin
                  rankD = rankQ + 4'd1;
               end
            end
            StShuffle: begin
               // Rejection sampling: out-of-range draws just retry next cycle.
               if (rnd <= idxQ) begin
                  swapWe = 1'b1;
                  idxD   = idxQ - 6'd1;
                  if (idxQ == 6'd1) begin
                     stateD = StReady;
                     idxD   = '0;
                     ptrD   = '0;
                  end
               end
            end
            StReady: begin
               if (i_draw_req) begin
                  cardD  = deck[ptrQ];
                  validD = 1'b1;
                  ptrD   = ptrQ + 6'd1;
                  if (ptrQ == LAST_IDX) begin
                     stateD = StEmpty;
                  end
               end
            end
            StEmpty: begin
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
               stateD = StFill;
               idxD   = '0;
               ptrD   = '0;
               rankD  = RANK_ACE;
               suitD  = '0;
`endif
            end
            default: begin
               stateD = StFill;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         stateQ <= StFill;
         idxQ   <= '0;
         ptrQ   <= '0;
         rankQ  <= RANK_ACE;
         suitQ  <= '0;
         cardQ  <= '0;
         validQ <= 1'b0;
      end else begin
         stateQ <= stateD;
         idxQ   <= idxD;
         ptrQ   <= ptrD;
         rankQ  <= rankD;
         suitQ  <= suitD;
         cardQ  <= cardD;
         validQ <= validD;
      end
   end

   // Deck storage is never reset; every fill rewrites all entries.
   // A swap with rnd == idxQ writes the same value twice, which is harmless.
   always_ff @(posedge i_clk) begin
      if (fillWe) begin
         deck[idxQ] <= '{suit: suitQ, rank: rankQ};
      end else if (swapWe) begin
         deck[idxQ] <= deck[rnd];
         deck[rnd]  <= deck[idxQ];
      end
   end

   always_comb begin
      o_card            = cardQ;
      o_card_valid      = validQ;
      o_ready           = (stateQ == StReady);
      o_empty           = (stateQ == StEmpty);
      o_cards_remaining = '0;
      if (stateQ == StReady || stateQ == StEmpty) begin
         o_cards_remaining = IDX_W'(DECK_SIZE) - ptrQ;
      end
   end

endmodule
